// File: rtl/ext_signals_input_capture.sv
// ---------------------------------------------------------------------------
// ext_signals_input_capture
//
// Receive side of the EXT signal pads. Each raw pad input is brought into the
// Clock domain with a 2-FF synchroniser, passed through a per-pad glitch
// filter and then routed (optionally inverted) onto a selectable bit of
// EXT_InputsVectorSignals. Configuration and readback go through the same
// command-frame interface as the output controller.
//
// Ports
//   Clock                    in   system clock, rising edge
//   Reset_N                  in   synchronous reset, active low
//   enable_cmd               in   command strobe, accepted only while busy=0
//   write_read               in   1=write, 0=read
//   addr_frame               in   register address
//   write_data_frame         in   write data
//   busy                     out  command in progress (one cycle per command)
//   read_data_frame          out  read data, held until the next accepted read
//   IO_Block_Y               in   raw asynchronous pad inputs
//   EXT_InputsVectorSignals  out  routed, filtered pad signals (registered)
//
// Command FSM
//   state   | meaning
//   ST_IDLE | waiting for enable_cmd; command fields captured on acceptance
//   ST_EXEC | busy=1; write applied / read data loaded at the end of this cycle
// ---------------------------------------------------------------------------
module ext_signals_input_capture #(
    parameter int N_PADS     = 10,
    parameter int VEC_WIDTH  = 32,
    parameter int FILT_WIDTH = 8
) (
    input  logic                  Clock,
    input  logic                  Reset_N,
    input  logic                  enable_cmd,
    input  logic                  write_read,
    input  logic [7:0]            addr_frame,
    input  logic [15:0]           write_data_frame,
    output logic                  busy,
    output logic [15:0]           read_data_frame,
    input  logic [N_PADS-1:0]     IO_Block_Y,
    output logic [VEC_WIDTH-1:0]  EXT_InputsVectorSignals
);

    localparam int IDX_W = 5;
    // Only the write-data bits some register actually uses are captured.
    localparam int WD_MAX1 = (N_PADS > FILT_WIDTH) ? N_PADS : FILT_WIDTH;
    localparam int WD_W    = (WD_MAX1 > 9) ? WD_MAX1 : 9;

    localparam logic [7:0] ADDR_FILT = 8'h10;
    localparam logic [7:0] ADDR_RAW  = 8'h20;
    localparam logic [7:0] ADDR_FLT  = 8'h21;
    localparam logic [7:0] ADDR_EDGE = 8'h22;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic                   cmd_accept;
    logic                   cmd_exec;
    logic                   cmd_write;
    logic                   cmd_read;

    logic                   cmd_wr_q, cmd_wr_d;
    logic [7:0]             cmd_addr_q, cmd_addr_d;
    logic [WD_W-1:0]        cmd_wdata_q, cmd_wdata_d;
    logic [15:0]            rdata_q, rdata_d;
    logic [15:0]            rd_val;

    logic [IDX_W-1:0]       route_idx_q [N_PADS];
    logic [IDX_W-1:0]       route_idx_d [N_PADS];
    logic [N_PADS-1:0]      route_en_q, route_en_d;
    logic [N_PADS-1:0]      route_inv_q, route_inv_d;
    logic [FILT_WIDTH-1:0]  filt_q, filt_d;

    logic [N_PADS-1:0]      sync1_q, sync1_d;
    logic [N_PADS-1:0]      sync2_q, sync2_d;
    logic [FILT_WIDTH-1:0]  cnt_q [N_PADS];
    logic [FILT_WIDTH-1:0]  cnt_d [N_PADS];
    logic [N_PADS-1:0]      flt_q, flt_d;
    logic [N_PADS-1:0]      edge_flag_q, edge_flag_d;
    logic [N_PADS-1:0]      edge_clr;
    logic [VEC_WIDTH-1:0]   ext_q, ext_d;

    // ---------------- command FSM: state register ----------------
    always_ff @(posedge Clock) begin
        if (!Reset_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- command FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable_cmd) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- command FSM: outputs ----------------
    always_comb begin
        busy       = 1'b0;
        cmd_accept = 1'b0;
        cmd_exec   = 1'b0;
        case (state_q)
            ST_IDLE: cmd_accept = enable_cmd;
            ST_EXEC: begin
                busy     = 1'b1;
                cmd_exec = 1'b1;
            end
            default: ;
        endcase
    end

    assign cmd_write = cmd_exec & cmd_wr_q;
    assign cmd_read  = cmd_exec & ~cmd_wr_q;

    // ---------------- command capture and register file ----------------
    always_comb begin
        cmd_wr_d    = cmd_wr_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        if (cmd_accept) begin
            cmd_wr_d    = write_read;
            cmd_addr_d  = addr_frame;
            cmd_wdata_d = write_data_frame[WD_W-1:0];
        end
    end

    always_comb begin
        route_idx_d = route_idx_q;
        route_en_d  = route_en_q;
        route_inv_d = route_inv_q;
        filt_d      = filt_q;
        edge_clr    = '0;
        if (cmd_write) begin
            for (int n = 0; n < N_PADS; n++) begin
                if (cmd_addr_q == 8'(n)) begin
                    route_idx_d[n] = cmd_wdata_q[IDX_W-1:0];
                    route_en_d[n]  = cmd_wdata_q[7];
                    route_inv_d[n] = cmd_wdata_q[8];
                end
            end
            if (cmd_addr_q == ADDR_FILT) filt_d   = cmd_wdata_q[FILT_WIDTH-1:0];
            if (cmd_addr_q == ADDR_EDGE) edge_clr = cmd_wdata_q[N_PADS-1:0];
        end
    end

    always_comb begin
        rd_val = '0;
        for (int n = 0; n < N_PADS; n++) begin
            if (cmd_addr_q == 8'(n)) begin
                rd_val = 16'({route_inv_q[n], route_en_q[n], 2'b00, route_idx_q[n]});
            end
        end
        case (cmd_addr_q)
            ADDR_FILT: rd_val = 16'(filt_q);
            ADDR_RAW:  rd_val = 16'(sync2_q);
            ADDR_FLT:  rd_val = 16'(flt_q);
            ADDR_EDGE: rd_val = 16'(edge_flag_q);
            default:   ;
        endcase
        rdata_d = cmd_read ? rd_val : rdata_q;
    end

    // ---------------- synchroniser, filter, edge flags ----------------
    assign sync1_d = IO_Block_Y;
    assign sync2_d = sync1_q;

    always_comb begin
        for (int n = 0; n < N_PADS; n++) begin
            cnt_d[n] = '0;
            flt_d[n] = flt_q[n];
            if (sync2_q[n] != flt_q[n]) begin
                // >= rather than == so that lowering F below a running count
                // still lets the pending level through on the next cycle.
                if (cnt_q[n] >= filt_q) begin
                    flt_d[n] = sync2_q[n];
                end else if (cnt_q[n] == '1) begin
                    cnt_d[n] = cnt_q[n];
                end else begin
                    cnt_d[n] = cnt_q[n] + 1'b1;
                end
            end
        end
    end

    // A rise in the same cycle as a clear wins, so no edge is ever lost.
    assign edge_flag_d = (edge_flag_q & ~edge_clr) | (flt_d & ~flt_q);

    // ---------------- routing ----------------
    always_comb begin
        ext_d = '0;
        for (int k = 0; k < VEC_WIDTH; k++) begin
            for (int n = 0; n < N_PADS; n++) begin
                if (route_en_q[n] && (int'(route_idx_q[n]) == k)) begin
                    ext_d[k] = ext_d[k] | (flt_q[n] ^ route_inv_q[n]);
                end
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge Clock) begin
        if (!Reset_N) begin
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rdata_q     <= '0;
            route_en_q  <= '0;
            route_inv_q <= '0;
            filt_q      <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            flt_q       <= '0;
            edge_flag_q <= '0;
            ext_q       <= '0;
            for (int n = 0; n < N_PADS; n++) begin
                route_idx_q[n] <= '0;
                cnt_q[n]       <= '0;
            end
        end else begin
            cmd_wr_q    <= cmd_wr_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            rdata_q     <= rdata_d;
            route_en_q  <= route_en_d;
            route_inv_q <= route_inv_d;
            filt_q      <= filt_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            flt_q       <= flt_d;
            edge_flag_q <= edge_flag_d;
            ext_q       <= ext_d;
            for (int n = 0; n < N_PADS; n++) begin
                route_idx_q[n] <= route_idx_d[n];
                cnt_q[n]       <= cnt_d[n];
            end
        end
    end

    assign read_data_frame         = rdata_q;
    assign EXT_InputsVectorSignals = ext_q;

endmodule

// File: tb/tb_ext_signals_input_capture.sv
module tb_ext_signals_input_capture;

    localparam int NP = 10;
    localparam int VW = 32;

    logic           Clock = 1'b0;
    logic           Reset_N = 1'b0;
    logic           enable_cmd = 1'b0;
    logic           write_read = 1'b0;
    logic [7:0]     addr_frame = '0;
    logic [15:0]    write_data_frame = '0;
    logic           busy;
    logic [15:0]    read_data_frame;
    logic [NP-1:0]  IO_Block_Y = '0;
    logic [VW-1:0]  EXT_InputsVectorSignals;

    ext_signals_input_capture #(.N_PADS(NP), .VEC_WIDTH(VW), .FILT_WIDTH(8)) dut (
        .Clock                   (Clock),
        .Reset_N                 (Reset_N),
        .enable_cmd              (enable_cmd),
        .write_read              (write_read),
        .addr_frame              (addr_frame),
        .write_data_frame        (write_data_frame),
        .busy                    (busy),
        .read_data_frame         (read_data_frame),
        .IO_Block_Y              (IO_Block_Y),
        .EXT_InputsVectorSignals (EXT_InputsVectorSignals)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Registers are kept as a plain address map of their read-back values;
    // the pad path is a 2-deep history plus a per-pad "cycles disagreeing" count.
    bit          m_busy;
    bit          m_wr;
    bit [7:0]    m_addr;
    bit [15:0]   m_wd;
    bit [15:0]   m_rd;
    bit [15:0]   m_route [NP];
    bit [7:0]    m_filt;
    bit [NP-1:0] m_s1, m_s2, m_flt, m_edge;
    int          m_cnt [NP];
    bit [VW-1:0] m_ext;

    function automatic bit [15:0] m_read(input bit [7:0] a);
        if (a < 8'(NP)) return m_route[a[3:0]];
        case (a)
            8'h10:   return {8'h00, m_filt};
            8'h20:   return 16'(m_s2);
            8'h21:   return 16'(m_flt);
            8'h22:   return 16'(m_edge);
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge Clock) begin : model
        bit [VW-1:0] next_ext;
        bit [NP-1:0] next_flt;
        bit [NP-1:0] clr;
        if (!Reset_N) begin
            m_busy = 0; m_wr = 0; m_addr = 0; m_wd = 0; m_rd = 0; m_filt = 0;
            m_s1 = 0; m_s2 = 0; m_flt = 0; m_edge = 0; m_ext = 0;
            for (int n = 0; n < NP; n++) begin
                m_route[n] = 0;
                m_cnt[n] = 0;
            end
        end else begin
            next_ext = '0;
            for (int n = 0; n < NP; n++) begin
                if (m_route[n][7]) begin
                    int t;
                    t = int'(m_route[n][4:0]);
                    if (t < VW) next_ext[t] = next_ext[t] | (m_flt[n] ^ m_route[n][8]);
                end
            end
            next_flt = m_flt;
            for (int n = 0; n < NP; n++) begin
                if (m_s2[n] != m_flt[n]) begin
                    if (m_cnt[n] >= int'(m_filt)) begin
                        next_flt[n] = m_s2[n];
                        m_cnt[n] = 0;
                    end else if (m_cnt[n] < 255) begin
                        m_cnt[n] = m_cnt[n] + 1;
                    end
                end else begin
                    m_cnt[n] = 0;
                end
            end
            clr = '0;
            if (m_busy) begin
                m_busy = 0;
                if (m_wr) begin
                    if (m_addr < 8'(NP)) m_route[m_addr[3:0]] = m_wd & 16'h019F;
                    else if (m_addr == 8'h10) m_filt = m_wd[7:0];
                    else if (m_addr == 8'h22) clr = m_wd[NP-1:0];
                end else begin
                    m_rd = m_read(m_addr);
                end
            end else if (enable_cmd) begin
                m_busy = 1;
                m_wr = write_read;
                m_addr = addr_frame;
                m_wd = write_data_frame;
            end
            m_edge = (m_edge & ~clr) | (next_flt & ~m_flt);
            m_flt = next_flt;
            m_ext = next_ext;
            m_s2 = m_s1;
            m_s1 = IO_Block_Y;
        end
    end

    always @(negedge Clock) begin
        if (check_en) begin
            cmp("busy_model", 32'(busy), 32'(m_busy));
            cmp("ext_model", EXT_InputsVectorSignals, m_ext);
            cmp("rdata_model", 32'(read_data_frame), 32'(m_rd));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic cmd(input bit wr, input bit [7:0] a, input bit [15:0] d);
        enable_cmd = 1'b1;
        write_read = wr;
        addr_frame = a;
        write_data_frame = d;
        tick();
        enable_cmd = 1'b0;
        cmp("busy_high", 32'(busy), 32'd1);
        tick();
        cmp("busy_low", 32'(busy), 32'd0);
    endtask

    task automatic rd_chk(input string nm, input bit [7:0] a, input bit [15:0] exp);
        cmd(1'b0, a, 16'h0000);
        cmp(nm, 32'(read_data_frame), 32'(exp));
    endtask

    initial begin
        tick(3);
        Reset_N = 1'b1;
        check_en = 1'b1;

        // reset state
        cmp("ext_reset", EXT_InputsVectorSignals, 32'h0);
        cmp("busy_reset", 32'(busy), 32'd0);
        rd_chk("rd_route0", 8'h00, 16'h0000);
        rd_chk("rd_filt", 8'h10, 16'h0000);
        rd_chk("rd_raw", 8'h20, 16'h0000);
        rd_chk("rd_flt", 8'h21, 16'h0000);
        rd_chk("rd_edge", 8'h22, 16'h0000);

        // basic route, F=0: output 4 edges after the pad edge
        cmd(1'b1, 8'h03, 16'h0085);
        rd_chk("rd_route3", 8'h03, 16'h0085);
        IO_Block_Y[3] = 1'b1;
        tick(3);
        cmp("lat_f0_edge3", EXT_InputsVectorSignals, 32'h0);
        tick();
        cmp("lat_f0_edge4", EXT_InputsVectorSignals, 32'h20);

        // glitch filter F=3
        cmd(1'b1, 8'h10, 16'h0003);
        cmd(1'b1, 8'h00, 16'h0080);
        IO_Block_Y = '0;
        tick(12);
        cmp("settled", EXT_InputsVectorSignals, 32'h0);
        IO_Block_Y[0] = 1'b1;
        tick(3);
        IO_Block_Y[0] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            cmp("pulse3_reject", 32'(EXT_InputsVectorSignals[0]), 32'd0);
        end
        IO_Block_Y[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 4) IO_Block_Y[0] = 1'b0;
            cmp("pulse4_pass", 32'(EXT_InputsVectorSignals[0]), 32'((k >= 7) && (k <= 10)));
        end

        // wired-OR with inversion
        cmd(1'b1, 8'h01, 16'h0182);
        cmd(1'b1, 8'h02, 16'h0082);
        cmp("wor_inv_low", EXT_InputsVectorSignals, 32'h4);
        IO_Block_Y[1] = 1'b1;
        tick(10);
        cmp("wor_inv_p1", EXT_InputsVectorSignals, 32'h0);
        IO_Block_Y[2] = 1'b1;
        tick(10);
        cmp("wor_p2", EXT_InputsVectorSignals, 32'h4);

        // edge flags
        cmd(1'b1, 8'h10, 16'h0000);
        IO_Block_Y = '0;
        tick(8);
        cmd(1'b1, 8'h22, 16'h03FF);
        rd_chk("edge_cleared", 8'h22, 16'h0000);
        IO_Block_Y[4] = 1'b1;
        tick(6);
        rd_chk("edge_set", 8'h22, 16'h0010);
        cmd(1'b1, 8'h22, 16'h0010);
        rd_chk("edge_w1c", 8'h22, 16'h0000);
        IO_Block_Y[4] = 1'b0;
        tick(6);
        IO_Block_Y[4] = 1'b1;
        tick();
        cmd(1'b1, 8'h22, 16'h0010);
        rd_chk("edge_set_wins", 8'h22, 16'h0010);
        cmd(1'b1, 8'h22, 16'h0010);
        rd_chk("edge_w1c2", 8'h22, 16'h0000);
        cmd(1'b1, 8'h21, 16'hFFFF);
        rd_chk("ro_write_ign", 8'h21, 16'h0010);
        rd_chk("unmapped", 8'h55, 16'h0000);

        // enable during busy is dropped
        enable_cmd = 1'b1; write_read = 1'b1; addr_frame = 8'h10; write_data_frame = 16'h0005;
        tick();
        cmp("busy_held1", 32'(busy), 32'd1);
        write_data_frame = 16'h0007;
        tick();
        enable_cmd = 1'b0;
        cmp("busy_ignored", 32'(busy), 32'd0);
        tick();
        cmp("not_queued", 32'(busy), 32'd0);
        rd_chk("filt_first", 8'h10, 16'h0005);

        // reset during EXEC
        cmd(1'b1, 8'h10, 16'h0000);
        enable_cmd = 1'b1; write_read = 1'b1; addr_frame = 8'h10; write_data_frame = 16'h0009;
        tick();
        enable_cmd = 1'b0;
        Reset_N = 1'b0;
        tick();
        cmp("busy_after_rst", 32'(busy), 32'd0);
        cmp("ext_after_rst", EXT_InputsVectorSignals, 32'h0);
        Reset_N = 1'b1;
        rd_chk("filt_abort", 8'h10, 16'h0000);
        rd_chk("route_abort", 8'h03, 16'h0000);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int r;
            if ($urandom_range(3) == 0) IO_Block_Y[$urandom_range(NP-1)] ^= 1'b1;
            if ($urandom_range(99) == 0) IO_Block_Y = NP'($urandom);
            enable_cmd = ($urandom_range(2) == 0);
            write_read = 1'($urandom_range(1));
            r = $urandom_range(7);
            case (r)
                0, 6:    addr_frame = 8'($urandom_range(NP-1));
                1, 7:    addr_frame = 8'h10;
                2:       addr_frame = 8'h20;
                3:       addr_frame = 8'h21;
                4:       addr_frame = 8'h22;
                default: addr_frame = 8'($urandom);
            endcase
            write_data_frame = (addr_frame == 8'h10) ? 16'($urandom_range(4)) : 16'($urandom);
            Reset_N = ($urandom_range(799) != 0);
            tick();
        end
        Reset_N = 1'b1;
        enable_cmd = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
